// File: rtl/game_sequencer.sv
// Central game scheduler: run/pause/over lifecycle, datapath sync reset,
// and a level-scaled move_tick strobe paced from the snake length.
module game_sequencer #(
    parameter int BASE_PERIOD = 5_000_000,
    parameter int PERIOD_STEP = 500_000,
    parameter int LEVEL_LEN   = 5,
    parameter int MAX_LEVEL   = 7,
    parameter int INIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       start_pb,
    input  logic       pause_pb,
    input  logic       goodColl,
    input  logic       badColl,
    input  logic       isGameComplete,
    input  logic [7:0] curr_length,
    output logic       sync,
    output logic       move_tick,
    output logic       apple_req,
    output logic [1:0] state,
    output logic       game_over,
    output logic       paused,
    output logic [3:0] level
);

    localparam int PW = $clog2(BASE_PERIOD + 1);
    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_PAUSE,
        S_OVER
    } fsm_t;

    fsm_t          fsm;
    logic          start_q;
    logic          pause_q;
    logic          good_q;
    logic [IW-1:0] init_cnt;
    logic [PW-1:0] tick_cnt;
    logic [PW-1:0] period;
    logic [7:0]    quot;
    logic [3:0]    lvl_next;
    logic          start_e;
    logic          pause_e;
    logic          good_e;
    logic          tick_last;
    logic          end_game;

    assign start_e  = start_pb & ~start_q;
    assign pause_e  = pause_pb & ~pause_q;
    assign good_e   = goodColl & ~good_q;
    assign end_game = badColl | isGameComplete;

    assign quot      = curr_length / 8'(LEVEL_LEN);
    assign lvl_next  = (quot > 8'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : quot[3:0];
    assign period    = PW'(BASE_PERIOD - int'(level) * PERIOD_STEP);
    // >= rather than == so a mid-count level bump cannot skip the wrap
    assign tick_last = (tick_cnt >= period - PW'(1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fsm       <= S_IDLE;
            start_q   <= 1'b1;
            pause_q   <= 1'b1;
            good_q    <= 1'b1;
            init_cnt  <= '0;
            tick_cnt  <= '0;
            sync      <= 1'b0;
            move_tick <= 1'b0;
            apple_req <= 1'b0;
            state     <= 2'd0;
            game_over <= 1'b0;
            paused    <= 1'b0;
            level     <= 4'd0;
        end else begin
            start_q   <= start_pb;
            pause_q   <= pause_pb;
            good_q    <= goodColl;
            level     <= lvl_next;
            move_tick <= 1'b0;
            apple_req <= 1'b0;
            case (fsm)
                S_IDLE: begin
                    if (start_e) begin
                        fsm      <= S_INIT;
                        state    <= 2'd1;
                        sync     <= 1'b1;
                        init_cnt <= '0;
                    end
                end
                S_INIT: begin
                    if (init_cnt == IW'(INIT_CYCLES - 1)) begin
                        fsm      <= S_RUN;
                        state    <= 2'd2;
                        sync     <= 1'b0;
                        tick_cnt <= '0;
                    end else begin
                        init_cnt <= init_cnt + IW'(1);
                    end
                end
                S_RUN: begin
                    if (end_game) begin
                        fsm       <= S_OVER;
                        state     <= 2'd0;
                        game_over <= 1'b1;
                    end else begin
                        apple_req <= good_e;
                        if (pause_e) begin
                            fsm    <= S_PAUSE;
                            state  <= 2'd3;
                            paused <= 1'b1;
                        end else if (tick_last) begin
                            move_tick <= 1'b1;
                            tick_cnt  <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + PW'(1);
                        end
                    end
                end
                S_PAUSE: begin
                    if (start_e) begin
                        fsm      <= S_INIT;
                        state    <= 2'd1;
                        sync     <= 1'b1;
                        paused   <= 1'b0;
                        init_cnt <= '0;
                    end else if (pause_e) begin
                        fsm    <= S_RUN;
                        state  <= 2'd2;
                        paused <= 1'b0;
                    end
                end
                S_OVER: begin
                    if (start_e) begin
                        fsm       <= S_INIT;
                        state     <= 2'd1;
                        sync      <= 1'b1;
                        game_over <= 1'b0;
                        init_cnt  <= '0;
                    end
                end
                default: begin
                    fsm       <= S_IDLE;
                    state     <= 2'd0;
                    sync      <= 1'b0;
                    game_over <= 1'b0;
                    paused    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Randomised and directed bench for game_sequencer against a
// cycle-level reference of the game lifecycle rules.
module tb_game_sequencer;

    localparam int BP = 8;
    localparam int PS = 2;
    localparam int LL = 4;
    localparam int ML = 2;
    localparam int IC = 3;

    localparam int M_IDLE  = 0;
    localparam int M_INIT  = 1;
    localparam int M_RUN   = 2;
    localparam int M_PAUSE = 3;
    localparam int M_OVER  = 4;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       start_pb = 1'b0;
    logic       pause_pb = 1'b0;
    logic       goodColl = 1'b0;
    logic       badColl = 1'b0;
    logic       isGameComplete = 1'b0;
    logic [7:0] curr_length = 8'd0;
    logic       sync;
    logic       move_tick;
    logic       apple_req;
    logic [1:0] state;
    logic       game_over;
    logic       paused;
    logic [3:0] level;

    game_sequencer #(
        .BASE_PERIOD(BP),
        .PERIOD_STEP(PS),
        .LEVEL_LEN  (LL),
        .MAX_LEVEL  (ML),
        .INIT_CYCLES(IC)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .start_pb      (start_pb),
        .pause_pb      (pause_pb),
        .goodColl      (goodColl),
        .badColl       (badColl),
        .isGameComplete(isGameComplete),
        .curr_length   (curr_length),
        .sync          (sync),
        .move_tick     (move_tick),
        .apple_req     (apple_req),
        .state         (state),
        .game_over     (game_over),
        .paused        (paused),
        .level         (level)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // reference: game mode, sync cycles left, RUN cycles since last tick
    int m;
    int sync_left;
    int run_cnt;
    int mlev;
    bit ps, pp, pg;
    bit e_tick, e_apple;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int lvl_of(input int len);
        return (len / LL > ML) ? ML : len / LL;
    endfunction

    task automatic model_reset();
        m = M_IDLE;
        sync_left = 0;
        run_cnt = 0;
        mlev = 0;
        ps = 1'b1;
        pp = 1'b1;
        pg = 1'b1;
        e_tick = 1'b0;
        e_apple = 1'b0;
    endtask

    task automatic model_edge();
        bit se, pe, ge;
        se = start_pb && !ps;
        pe = pause_pb && !pp;
        ge = goodColl && !pg;
        e_tick = 1'b0;
        e_apple = 1'b0;
        case (m)
            M_IDLE: if (se) begin m = M_INIT; sync_left = IC; end
            M_INIT: begin
                sync_left--;
                if (sync_left == 0) begin m = M_RUN; run_cnt = 0; end
            end
            M_RUN: begin
                if (badColl || isGameComplete) begin
                    m = M_OVER;
                end else begin
                    e_apple = ge;
                    if (pe) begin
                        m = M_PAUSE;
                    end else begin
                        run_cnt++;
                        if (run_cnt >= BP - mlev * PS) begin
                            e_tick = 1'b1;
                            run_cnt = 0;
                        end
                    end
                end
            end
            M_PAUSE: begin
                if (se) begin m = M_INIT; sync_left = IC; end
                else if (pe) m = M_RUN;
            end
            default: if (se) begin m = M_INIT; sync_left = IC; end
        endcase
        ps = start_pb;
        pp = pause_pb;
        pg = goodColl;
        mlev = lvl_of(int'(curr_length));
    endtask

    task automatic check_outs();
        int es;
        es = (m == M_INIT) ? 1 : (m == M_RUN) ? 2 : (m == M_PAUSE) ? 3 : 0;
        chk("state", 32'(state), 32'(es));
        chk("sync", 32'(sync), 32'(m == M_INIT));
        chk("move_tick", 32'(move_tick), 32'(e_tick));
        chk("apple_req", 32'(apple_req), 32'(e_apple));
        chk("game_over", 32'(game_over), 32'(m == M_OVER));
        chk("paused", 32'(paused), 32'(m == M_PAUSE));
        chk("level", 32'(level), 32'(mlev));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            model_edge();
            check_outs();
        end
    endtask

    task automatic wait_tick(input int budget, output int t);
        t = 0;
        do begin
            step(1);
            t++;
        end while (!move_tick && t < budget);
        if (!move_tick) chk("tick_timeout", 32'(move_tick), 32'd1);
    endtask

    task automatic count_sync(output int ns, output int k);
        ns = 0;
        k = 0;
        while (state != 2'd2 && k < 10) begin
            if (sync) ns++;
            step(1);
            k++;
        end
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_sync"}, 32'(sync), 32'd0);
        chk({tag, "_tick"}, 32'(move_tick), 32'd0);
        chk({tag, "_apple"}, 32'(apple_req), 32'd0);
        chk({tag, "_over"}, 32'(game_over), 32'd0);
        chk({tag, "_paused"}, 32'(paused), 32'd0);
        chk({tag, "_level"}, 32'(level), 32'd0);
    endtask

    int t, ns, k, apples;

    initial begin
        model_reset();
        #12;
        reset_check("rst");
        @(negedge clk);
        nrst = 1'b1;
        step(2);

        // start sequence
        start_pb = 1'b1;
        step(1);
        start_pb = 1'b0;
        count_sync(ns, k);
        chk("sync_cycles", 32'(ns), 32'd3);
        chk("run_entry", 32'(k), 32'd3);
        wait_tick(20, t);
        chk("first_tick", 32'(t), 32'd8);
        wait_tick(20, t);
        chk("tick_l0", 32'(t), 32'd8);

        // speed scaling
        curr_length = 8'd4;
        wait_tick(20, t);
        wait_tick(20, t);
        chk("tick_l1", 32'(t), 32'd6);
        curr_length = 8'd20;
        wait_tick(20, t);
        wait_tick(20, t);
        chk("tick_l2", 32'(t), 32'd4);
        curr_length = 8'd0;
        wait_tick(20, t);
        wait_tick(20, t);
        step(6);
        curr_length = 8'd20;
        wait_tick(20, t);
        chk("tick_raise_at6", 32'(t), 32'd2);

        // pause round-trip
        curr_length = 8'd0;
        wait_tick(20, t);
        wait_tick(20, t);
        step(5);
        pause_pb = 1'b1;
        step(1);
        pause_pb = 1'b0;
        chk("paused_now", 32'(paused), 32'd1);
        apples = 0;
        for (int i = 0; i < 19; i++) begin
            goodColl = (i >= 4 && i < 9);
            step(1);
            if (apple_req) apples++;
        end
        chk("pause_apples", 32'(apples), 32'd0);
        pause_pb = 1'b1;
        step(1);
        pause_pb = 1'b0;
        wait_tick(20, t);
        chk("tick_after_pause", 32'(t), 32'd3);

        // one apple for a long goodColl, then collision priority
        goodColl = 1'b1;
        apples = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (apple_req) apples++;
        end
        goodColl = 1'b0;
        chk("apple_once", 32'(apples), 32'd1);
        wait_tick(20, t);
        step(7);
        badColl = 1'b1;
        step(1);
        badColl = 1'b0;
        chk("bad_no_tick", 32'(move_tick), 32'd0);
        chk("bad_over", 32'(game_over), 32'd1);
        step(12);

        // restart from OVER, start ignored in RUN
        start_pb = 1'b1;
        step(1);
        start_pb = 1'b0;
        chk("restart_over_clr", 32'(game_over), 32'd0);
        count_sync(ns, k);
        chk("restart_sync", 32'(ns), 32'd3);
        step(2);
        start_pb = 1'b1;
        step(2);
        start_pb = 1'b0;
        step(1);
        chk("start_in_run", 32'(state), 32'd2);

        // async reset mid-INIT, start held through release
        isGameComplete = 1'b1;
        step(1);
        isGameComplete = 1'b0;
        start_pb = 1'b1;
        step(2);
        chk("init_sync", 32'(sync), 32'd1);
        #2;
        nrst = 1'b0;
        #1;
        reset_check("async");
        model_reset();
        @(negedge clk);
        nrst = 1'b1;
        step(3);
        chk("held_start_idle", 32'(state), 32'd0);
        start_pb = 1'b0;
        step(1);

        // randomized play
        for (int i = 0; i < 3000; i++) begin
            start_pb = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 24) == 0) pause_pb = ~pause_pb;
            goodColl = ($urandom_range(0, 3) == 0);
            badColl = ($urandom_range(0, 149) == 0);
            isGameComplete = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 59) == 0)
                curr_length = 8'($urandom_range(0, 40));
            step(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
